// File: rtl/bxx_resolve.sv
// bxx_resolve: in-order tracker of predicted conditional branches. It compares each
// prediction with the resolved outcome and issues a one-cycle fetch redirect on a miss.
module bxx_resolve #(
    parameter int PC_SIZE = 32,
    parameter int DEPTH   = 4,
    parameter int CNT_W   = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enq_valid,
    input  logic [PC_SIZE-1:0] enq_pc,
    input  logic               enq_take,
    input  logic               res_valid,
    input  logic               res_taken,
    input  logic [PC_SIZE-1:0] res_imm,
    output logic               predict_fail,
    output logic [PC_SIZE-1:0] bxx_fail_pc,
    output logic [PC_SIZE-1:0] bxx_fail_imm,
    output logic               fifo_full,
    output logic               fifo_empty,
    output logic [CNT_W-1:0]   branch_cnt,
    output logic [CNT_W-1:0]   miss_cnt,
    output logic               err
);

    localparam int                 PTR_W         = $clog2(DEPTH);
    localparam logic [PTR_W:0]     FULL_COUNT    = (PTR_W + 1)'(DEPTH);
    localparam logic [PC_SIZE-1:0] NOT_TAKEN_IMM = PC_SIZE'(4);

    logic [PC_SIZE-1:0] pc_mem_q [DEPTH];
    logic [DEPTH-1:0]   take_mem_q;

    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]     count_q, count_d;
    logic               predict_fail_q, predict_fail_d;
    logic [PC_SIZE-1:0] fail_pc_q, fail_pc_d;
    logic [PC_SIZE-1:0] fail_imm_q, fail_imm_d;
    logic [CNT_W-1:0]   branch_cnt_q, branch_cnt_d;
    logic [CNT_W-1:0]   miss_cnt_q, miss_cnt_d;
    logic               err_q, err_d;

    logic               full;
    logic               empty;
    logic               do_enq;
    logic               do_res;
    logic               mismatch;
    logic [PC_SIZE-1:0] head_pc;
    logic               head_take;

    assign full      = (count_q == FULL_COUNT);
    assign empty     = (count_q == '0);
    assign head_pc   = pc_mem_q[rd_ptr_q];
    assign head_take = take_mem_q[rd_ptr_q];

    // While the redirect pulse is high, both fetch and execute slots are squashed
    // instructions, so neither side may touch the queue or the error flag.
    assign do_enq   = enq_valid && !full && !predict_fail_q;
    assign do_res   = res_valid && !empty && !predict_fail_q;
    assign mismatch = do_res && (head_take != res_taken);

    always_comb begin
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        count_d        = count_q;
        predict_fail_d = mismatch;
        fail_pc_d      = fail_pc_q;
        fail_imm_d     = fail_imm_q;
        branch_cnt_d   = branch_cnt_q;
        miss_cnt_d     = miss_cnt_q;
        err_d          = err_q;

        if (!predict_fail_q) begin
            if (enq_valid && full) begin
                err_d = 1'b1;
            end
            if (res_valid && empty) begin
                err_d = 1'b1;
            end
        end

        if (do_res) begin
            branch_cnt_d = branch_cnt_q + CNT_W'(1);
        end

        if (mismatch) begin
            // A miss discards every younger branch, including one enqueued this cycle.
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            miss_cnt_d = miss_cnt_q + CNT_W'(1);
            fail_pc_d  = head_pc;
            fail_imm_d = res_taken ? res_imm : NOT_TAKEN_IMM;
        end else begin
            if (do_enq) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (do_res) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + (PTR_W + 1)'(do_enq) - (PTR_W + 1)'(do_res);
        end
    end

    // Entry storage carries no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_enq) begin
            pc_mem_q[wr_ptr_q]   <= enq_pc;
            take_mem_q[wr_ptr_q] <= enq_take;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            predict_fail_q <= 1'b0;
            fail_pc_q      <= '0;
            fail_imm_q     <= '0;
            branch_cnt_q   <= '0;
            miss_cnt_q     <= '0;
            err_q          <= 1'b0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            predict_fail_q <= predict_fail_d;
            fail_pc_q      <= fail_pc_d;
            fail_imm_q     <= fail_imm_d;
            branch_cnt_q   <= branch_cnt_d;
            miss_cnt_q     <= miss_cnt_d;
            err_q          <= err_d;
        end
    end

    assign predict_fail = predict_fail_q;
    assign bxx_fail_pc  = fail_pc_q;
    assign bxx_fail_imm = fail_imm_q;
    assign fifo_full    = full;
    assign fifo_empty   = empty;
    assign branch_cnt   = branch_cnt_q;
    assign miss_cnt     = miss_cnt_q;
    assign err          = err_q;

endmodule

// File: tb/tb_bxx_resolve.sv
// Self-checking bench for bxx_resolve: directed scenarios followed by random traffic,
// all compared against a queue-based reference model of the branch tracker.
module tb_bxx_resolve;

    localparam int PC_SIZE = 32;
    localparam int DEPTH   = 4;
    localparam int CNT_W   = 32;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               enqValid;
    logic [PC_SIZE-1:0] enqPc;
    logic               enqTake;
    logic               resValid;
    logic               resTaken;
    logic [PC_SIZE-1:0] resImm;
    logic               predictFail;
    logic [PC_SIZE-1:0] failPc;
    logic [PC_SIZE-1:0] failImm;
    logic               fifoFull;
    logic               fifoEmpty;
    logic [CNT_W-1:0]   branchCnt;
    logic [CNT_W-1:0]   missCnt;
    logic               errOut;

    typedef struct {
        logic [PC_SIZE-1:0] pc;
        logic               take;
    } entryT;

    entryT              modelQ[$];
    logic               mPf;
    logic [PC_SIZE-1:0] mFailPc;
    logic [PC_SIZE-1:0] mFailImm;
    longint unsigned    mBranch;
    longint unsigned    mMiss;
    logic               mErr;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    bxx_resolve #(.PC_SIZE(PC_SIZE), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enq_valid   (enqValid),
        .enq_pc      (enqPc),
        .enq_take    (enqTake),
        .res_valid   (resValid),
        .res_taken   (resTaken),
        .res_imm     (resImm),
        .predict_fail(predictFail),
        .bxx_fail_pc (failPc),
        .bxx_fail_imm(failImm),
        .fifo_full   (fifoFull),
        .fifo_empty  (fifoEmpty),
        .branch_cnt  (branchCnt),
        .miss_cnt    (missCnt),
        .err         (errOut)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic modelReset();
        modelQ.delete();
        mPf      = 1'b0;
        mFailPc  = '0;
        mFailImm = '0;
        mBranch  = 0;
        mMiss    = 0;
        mErr     = 1'b0;
    endtask

    // Reference behaviour for one rising edge, given the inputs currently applied.
    task automatic modelStep();
        int    sizeBefore;
        logic  miss;
        entryT head;
        sizeBefore = modelQ.size();
        miss = 1'b0;
        if (mPf) begin
            mPf = 1'b0;
        end else begin
            if (resValid) begin
                if (sizeBefore == 0) begin
                    mErr = 1'b1;
                end else begin
                    head = modelQ.pop_front();
                    mBranch = (mBranch + 1) % (64'd1 << CNT_W);
                    if (head.take != resTaken) begin
                        miss     = 1'b1;
                        mMiss    = (mMiss + 1) % (64'd1 << CNT_W);
                        mFailPc  = head.pc;
                        mFailImm = resTaken ? resImm : 32'h4;
                    end
                end
            end
            if (enqValid) begin
                if (sizeBefore == DEPTH) begin
                    mErr = 1'b1;
                end else if (!miss) begin
                    modelQ.push_back('{pc: enqPc, take: enqTake});
                end
            end
            if (miss) begin
                modelQ.delete();
            end
            mPf = miss;
        end
    endtask

    task automatic checkAll(input string where);
        checkOutput({where, ".predict_fail"}, 64'(predictFail), 64'(mPf));
        checkOutput({where, ".fail_pc"},      64'(failPc),      64'(mFailPc));
        checkOutput({where, ".fail_imm"},     64'(failImm),     64'(mFailImm));
        checkOutput({where, ".fifo_full"},    64'(fifoFull),    64'(modelQ.size() == DEPTH));
        checkOutput({where, ".fifo_empty"},   64'(fifoEmpty),   64'(modelQ.size() == 0));
        checkOutput({where, ".branch_cnt"},   64'(branchCnt),   mBranch);
        checkOutput({where, ".miss_cnt"},     64'(missCnt),     mMiss);
        checkOutput({where, ".err"},          64'(errOut),      64'(mErr));
    endtask

    task automatic applyStimulus(input string where, input logic ev, input logic [PC_SIZE-1:0] pc,
                                 input logic take, input logic rv, input logic rt,
                                 input logic [PC_SIZE-1:0] imm);
        enqValid = ev;
        enqPc    = pc;
        enqTake  = take;
        resValid = rv;
        resTaken = rt;
        resImm   = imm;
        @(posedge clk);
        modelStep();
        #1;
        checkAll(where);
        enqValid = 1'b0;
        resValid = 1'b0;
    endtask

    task automatic idleCycle(input string where);
        applyStimulus(where, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic doReset();
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        modelReset();
        checkAll("reset");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic errBefore;
    logic headTake;

    initial begin
        rst_n    = 1'b0;
        enqValid = 1'b0;
        enqPc    = '0;
        enqTake  = 1'b0;
        resValid = 1'b0;
        resTaken = 1'b0;
        resImm   = '0;
        modelReset();
        #12;
        checkAll("por");
        @(negedge clk);
        rst_n = 1'b1;
        idleCycle("post_reset");

        // predicted taken, actually not taken
        applyStimulus("tnt_enq", 1'b1, 32'h100, 1'b1, 1'b0, 1'b0, '0);
        idleCycle("tnt_wait");
        applyStimulus("tnt_res", 1'b0, '0, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFF0);
        checkOutput("tnt_pulse", 64'(predictFail), 64'd1);
        checkOutput("tnt_pc",    64'(failPc),      64'h100);
        checkOutput("tnt_imm",   64'(failImm),     64'h4);
        checkOutput("tnt_miss",  64'(missCnt),     64'd1);
        checkOutput("tnt_empty", 64'(fifoEmpty),   64'd1);
        idleCycle("tnt_after");
        checkOutput("tnt_one_shot", 64'(predictFail), 64'd0);

        // predicted not taken, actually taken; then async reset during the pulse
        applyStimulus("ntt_enq", 1'b1, 32'h200, 1'b0, 1'b0, 1'b0, '0);
        applyStimulus("ntt_res", 1'b0, '0, 1'b0, 1'b1, 1'b1, 32'h40);
        checkOutput("ntt_pc",  64'(failPc),           64'h200);
        checkOutput("ntt_imm", 64'(failImm),          64'h40);
        checkOutput("ntt_sum", 64'(failPc + failImm), 64'h240);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_clr_pf",  64'(predictFail), 64'd0);
        checkOutput("async_clr_pc",  64'(failPc),      64'd0);
        checkOutput("async_clr_cnt", 64'(branchCnt),   64'd0);
        modelReset();
        @(negedge clk);
        rst_n = 1'b1;

        // fill, overflow, then flush on a miss
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus("fill", 1'b1, 32'h300 + 32'(i * 4), 1'b0, 1'b0, 1'b0, '0);
        end
        checkOutput("fill_full", 64'(fifoFull), 64'd1);
        applyStimulus("fill_over", 1'b1, 32'h400, 1'b0, 1'b0, 1'b0, '0);
        checkOutput("fill_err", 64'(errOut), 64'd1);
        applyStimulus("fill_miss", 1'b0, '0, 1'b0, 1'b1, 1'b1, 32'h20);
        checkOutput("fill_pulse",  64'(predictFail), 64'd1);
        checkOutput("fill_branch", 64'(branchCnt),   64'd1);
        checkOutput("fill_pc",     64'(failPc),      64'h300);
        checkOutput("fill_empty",  64'(fifoEmpty),   64'd1);
        idleCycle("fill_after");

        // concurrent matching pairs across the pointer wrap
        doReset();
        applyStimulus("wrap_prime", 1'b1, 32'h1000, 1'b1, 1'b0, 1'b0, '0);
        for (int i = 0; i < 10; i++) begin
            headTake = modelQ[0].take;
            applyStimulus("wrap_pair", 1'b1, 32'h1004 + 32'(i * 4), 1'(i % 2), 1'b1, headTake, 32'h80);
            checkOutput("wrap_no_pulse", 64'(predictFail), 64'd0);
        end
        checkOutput("wrap_branch", 64'(branchCnt), 64'd10);
        checkOutput("wrap_miss",   64'(missCnt),   64'd0);
        headTake = modelQ[0].take;
        applyStimulus("wrap_drain", 1'b0, '0, 1'b0, 1'b1, headTake, '0);
        checkOutput("wrap_drained", 64'(fifoEmpty), 64'd1);

        // squash window: both requests during the pulse are ignored
        applyStimulus("sq_enq", 1'b1, 32'h500, 1'b1, 1'b0, 1'b0, '0);
        applyStimulus("sq_miss", 1'b0, '0, 1'b0, 1'b1, 1'b0, '0);
        errBefore = errOut;
        applyStimulus("sq_window", 1'b1, 32'h600, 1'b1, 1'b1, 1'b1, 32'h8);
        checkOutput("sq_pulse_end", 64'(predictFail), 64'd0);
        checkOutput("sq_empty",     64'(fifoEmpty),   64'd1);
        checkOutput("sq_err",       64'(errOut),      64'(errBefore));
        applyStimulus("sq_res_empty", 1'b0, '0, 1'b0, 1'b1, 1'b0, '0);
        checkOutput("empty_res_err",   64'(errOut),      64'd1);
        checkOutput("empty_res_pulse", 64'(predictFail), 64'd0);

        // random traffic
        doReset();
        for (int i = 0; i < 600; i++) begin
            logic ev, rv, rt;
            ev = ($urandom_range(0, 99) < 55);
            rv = ($urandom_range(0, 99) < 45);
            if (modelQ.size() > 0 && $urandom_range(0, 99) < 80) begin
                rt = modelQ[0].take;
            end else begin
                rt = 1'($urandom);
            end
            applyStimulus("rand", ev, $urandom & 32'hFFFF_FFFC, 1'($urandom), rv, rt,
                          $urandom & 32'hFFFF_FFFE);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bxx_resolve.md
# bxx_resolve

Branch-resolution tracker at the execute end of the static branch-prediction path. It records each conditional branch as it leaves fetch, together with its predicted direction. When execute reports the real outcome of the oldest branch, it compares the two. On a mismatch it drives the one-cycle `predict_fail` / `bxx_fail_pc` / `bxx_fail_imm` redirect that fetch consumes, where fetch computes next pc = `bxx_fail_pc` + `bxx_fail_imm`.

## Interface
Parameters:
- `PC_SIZE`, 32, width of pc and offsets.
- `DEPTH`, 4, number of in-flight branches tracked; power of two, ≥2.
- `CNT_W`, 32, width of statistics counters.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `enq_valid` in 1: fetch issues a bxx this cycle (not nop-selected).
- `enq_pc` in `PC_SIZE`: pc of that branch.
- `enq_take` in 1: predicted direction (1 = taken).
- `res_valid` in 1: execute resolves the oldest in-flight branch.
- `res_taken` in 1: actual direction.
- `res_imm` in `PC_SIZE`: sign-extended B-type offset of the resolving branch.
- `predict_fail` out 1: redirect pulse to fetch.
- `bxx_fail_pc` out `PC_SIZE`: base of the redirect sum.
- `bxx_fail_imm` out `PC_SIZE`: offset of the redirect sum.
- `fifo_full` out 1: count == `DEPTH`; fetch must stall bxx issue.
- `fifo_empty` out 1: count == 0.
- `branch_cnt` out `CNT_W`: branches resolved.
- `miss_cnt` out `CNT_W`: mispredictions.
- `err` out 1: sticky protocol error.

## Operation
- The block is an in-order FIFO of {pc, take}. It uses `DEPTH` entries, write/read pointers of log2(`DEPTH`) bits that wrap modulo `DEPTH`, and a count of log2(`DEPTH`)+1 bits.
- **Enqueue:** occurs on `enq_valid` && !`fifo_full` && !`predict_fail`.
  - `enq_valid` while full drops the entry and sets `err`.
  - `enq_valid` while `predict_fail`=1 is ignored silently, because that fetch slot is a nop.
- **Resolve:** occurs on `res_valid` && !`fifo_empty` && !`predict_fail`. It pops the head and increments `branch_cnt`.
  - `res_valid` while empty does nothing to the queue and sets `err`.
  - `res_valid` while `predict_fail`=1 is ignored: it belongs to a squashed instruction.
- **Mismatch** (head.take != `res_taken`):
  - Increment `miss_cnt`.
  - Register the redirect: `bxx_fail_pc` = head.pc.
  - `bxx_fail_imm` = `res_imm` when actually taken, or 32'h4 when actually not taken. The sum is modulo 2^`PC_SIZE`.
  - Flush the whole queue at the same edge: pointers and count go to 0, so younger branches are discarded. A same-cycle enqueue is also discarded.
- **Match:** pop only. The redirect outputs hold their previous values and `predict_fail`=0.
- **Simultaneous enqueue and matching resolve:** allowed when not full, and the count is unchanged. When full, the enqueue is dropped (with `err` set), even though a pop occurs.
- Counters wrap at 2^`CNT_W`.
- `err` is cleared only by reset.

## Timing
- Reset (async assert, sync deassert at the flop level via the async clear) sets:
  - `predict_fail`=0, `bxx_fail_pc`=0, `bxx_fail_imm`=0;
  - pointers and count = 0, so `fifo_empty`=1 and `fifo_full`=0;
  - both counters = 0, `err`=0.
- Resolve-to-redirect latency is 1 cycle: a mismatch seen at edge N drives `predict_fail`=1 during cycle N..N+1. It is a pulse of exactly one cycle. A second `res_valid` during that cycle is ignored, so back-to-back pulses cannot occur.
- `fifo_full` and `fifo_empty` are decoded from registered count, so they change one edge after the enqueue or pop.
- Queue contents are not data-reset; only the pointers are cleared.
- Reset asserted mid-operation discards all in-flight entries and any pending pulse immediately.

## Test plan
- **Reset:** hold `rst_n`=0 and then release → all outputs are 0 except `fifo_empty`=1. Asserting `rst_n` asynchronously mid-cycle while `predict_fail`=1 clears it without waiting for a clock edge.
- **Predicted taken, actually not taken:**
  - Stimulus: enqueue pc=0x100, take=1; later `res_valid`, `res_taken`=0, `res_imm`=0xFFFFFFF0.
  - Required: next cycle `predict_fail`=1, `bxx_fail_pc`=0x100, `bxx_fail_imm`=0x4, `miss_cnt`=1, `fifo_empty`=1.
- **Predicted not taken, actually taken:**
  - Stimulus: enqueue 0x200/take=0, then resolve with `res_taken`=1, `res_imm`=0x40.
  - Required: `bxx_fail_pc`=0x200, `bxx_fail_imm`=0x40 (sum 0x240).
- **Fill and flush:**
  - Enqueue 4 branches all take=0 → `fifo_full`=1. A 5th `enq_valid` is dropped and `err`=1.
  - Resolve the first as taken → pulse fires, `branch_cnt`=1, and the 3 remaining entries are flushed (`fifo_empty`=1 the next cycle).
- **Matches with pointer wrap:**
  - Run 10 enqueue/resolve pairs, concurrent in the same cycle, all matching.
  - Required: no pulse, `branch_cnt`=10, `miss_cnt`=0, and correct FIFO order across the pointer wrap.
- **Squash window:**
  - Stimulus: during the `predict_fail` cycle, assert `enq_valid` and `res_valid`.
  - Required: both ignored, count stays 0, `err` unchanged.
  - Also: `res_valid` with an empty queue → `err`=1 and no pulse.
